// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses InstrMemory and registers the
// returned word into an IF/ID slot that decode drains with a valid/ready handshake.
module fetch_stage #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic [31:0]      imem_rd_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [31:0]      id_instr_o,
    output logic [WIDTH-1:0] id_pc_o,
    output logic [WIDTH-1:0] id_pc_next_o,
    output logic             dbg_state_o
);

    // Handshake: a word moves from IF/ID to decode on a rising edge where
    // id_valid_o && id_ready_i; id_valid_o never depends combinationally on id_ready_i.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic             r_id_valid;
    logic [31:0]      r_id_instr;
    logic [WIDTH-1:0] r_id_pc;
    logic [WIDTH-1:0] r_id_pc_next;
    logic             w_load;
    logic             w_drain;

    assign w_pc_inc = r_pc + PC_STEP;
    assign w_load   = (r_state == RUN) && en_i && (!r_id_valid || id_ready_i);
    assign w_drain  = r_id_valid && id_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // A redirect never changes the run state: IDLE stays IDLE, RUN keeps fetching.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (en_i && !redirect_i) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (!en_i && !redirect_i) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_id_valid   <= 1'b0;
            r_id_instr   <= 32'h0;
            r_id_pc      <= '0;
            r_id_pc_next <= '0;
        end else if (redirect_i) begin
            // Wrong-path word is discarded even if decode is stalled.
            r_pc       <= redirect_pc_i;
            r_id_valid <= 1'b0;
        end else if (w_load) begin
            r_id_instr   <= imem_rd_i;
            r_id_pc      <= r_pc;
            r_id_pc_next <= w_pc_inc;
            r_id_valid   <= 1'b1;
            r_pc         <= w_pc_inc;
        end else if (w_drain) begin
            r_id_valid <= 1'b0;
        end
    end

    assign imem_addr_o  = r_pc;
    assign id_valid_o   = r_id_valid;
    assign id_instr_o   = r_id_instr;
    assign id_pc_o      = r_id_pc;
    assign id_pc_next_o = r_id_pc_next;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked by a
// word-level reference model feeding an expected queue drained by a monitor.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ready;
    logic        redir;
    logic [7:0]  rpc;
    logic [7:0]  addr;
    logic [31:0] rd;
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic [7:0]  pc_next;
    logic        state;

    logic        w_rst;
    logic        w_en;
    logic [7:0]  w_addr;
    logic [31:0] w_rd;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [7:0]  w_pc;
    logic [7:0]  w_pc_next;
    logic        w_state;

    logic [31:0] mem [256];

    int n_chk = 0;
    int n_err = 0;

    logic [47:0] exp_q[$];
    logic [7:0]  m_pc;
    logic        m_valid;
    logic        m_running;

    assign rd   = mem[addr];
    assign w_rd = mem[w_addr];

    fetch_stage #(.WIDTH(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst(rst), .en_i(en), .imem_addr_o(addr), .imem_rd_i(rd),
        .redirect_i(redir), .redirect_pc_i(rpc), .id_valid_o(valid), .id_ready_i(ready),
        .id_instr_o(instr), .id_pc_o(pc), .id_pc_next_o(pc_next), .dbg_state_o(state)
    );

    fetch_stage #(.WIDTH(8), .RESET_PC(8'hFE)) u_wrap (
        .clk(clk), .rst(w_rst), .en_i(w_en), .imem_addr_o(w_addr), .imem_rd_i(w_rd),
        .redirect_i(1'b0), .redirect_pc_i(8'h00), .id_valid_o(w_valid), .id_ready_i(1'b1),
        .id_instr_o(w_instr), .id_pc_o(w_pc), .id_pc_next_o(w_pc_next), .dbg_state_o(w_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the program counter, whether fetching is switched on and whether the
    // decode slot is occupied; every word that will reach decode is queued in order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc      = 8'h00;
            m_valid   = 1'b0;
            m_running = 1'b0;
        end else if (redir) begin
            if (m_valid && !ready) void'(exp_q.pop_back());
            m_valid = 1'b0;
            m_pc    = rpc;
        end else begin
            if (m_running && en && (!m_valid || ready)) begin
                exp_q.push_back({mem[m_pc], m_pc, m_pc + 8'd1});
                m_valid = 1'b1;
                m_pc    = m_pc + 8'd1;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            m_running = en;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_vs_model", {47'd0, valid}, {47'd0, m_valid});
            chk("imem_addr_vs_model", {40'd0, addr}, {40'd0, m_pc});
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {instr, pc, pc_next}, 48'hx);
                end else begin
                    chk("accepted_word", {instr, pc, pc_next}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] held_addr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h20010003;
        rst = 1'b1; w_rst = 1'b1;
        en = 1'b0; ready = 1'b0; redir = 1'b0; rpc = 8'h00; w_en = 1'b0;
        #2;
        chk("rst_valid", {47'd0, valid}, 48'd0);
        chk("rst_instr", {16'd0, instr}, 48'd0);
        chk("rst_pc", {40'd0, pc}, 48'd0);
        chk("rst_pc_next", {40'd0, pc_next}, 48'd0);
        chk("rst_addr", {40'd0, addr}, 48'd0);
        chk("rst_state", {47'd0, state}, 48'd0);
        chk("rst_wrap_addr", {40'd0, w_addr}, 48'hFE);

        @(negedge clk);
        rst = 1'b0; w_rst = 1'b0;
        step();
        en = 1'b1; ready = 1'b1; w_en = 1'b1;

        // First fetch: IDLE->RUN on edge 1, first word on edge 2.
        step();
        chk("first_edge_valid", {47'd0, valid}, 48'd0);
        step();
        chk("second_edge_valid", {47'd0, valid}, 48'd1);
        chk("first_pc", {40'd0, pc}, 48'd0);
        chk("first_instr", {16'd0, instr}, {16'd0, 32'h20010003});
        chk("wrap_pc_fe", {40'd0, w_pc, w_pc_next}, {32'd0, 8'hFE, 8'hFF});
        chk("wrap_instr_fe", {16'd0, w_instr}, {16'd0, mem[8'hFE]});
        step();
        chk("wrap_pc_ff", {40'd0, w_pc, w_pc_next}, {32'd0, 8'hFF, 8'h00});
        step();
        chk("wrap_pc_00", {40'd0, w_pc, w_pc_next}, {32'd0, 8'h00, 8'h01});
        chk("wrap_instr_00", {16'd0, w_instr}, {16'd0, mem[8'h00]});
        chk("pc_before_stall", {40'd0, pc}, 48'd2);

        // Stall three cycles with word 2 held.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", {40'd0, pc}, 48'd2);
            chk("stall_instr", {16'd0, instr}, {16'd0, mem[2]});
            chk("stall_addr", {40'd0, addr}, 48'd3);
        end
        ready = 1'b1;
        step();
        chk("after_stall_pc3", {40'd0, pc}, 48'd3);
        step();
        chk("after_stall_pc4", {40'd0, pc}, 48'd4);

        // Redirect to 1: one bubble, then target.
        redir = 1'b1; rpc = 8'd1;
        step();
        redir = 1'b0;
        chk("redirect_bubble", {47'd0, valid}, 48'd0);
        step();
        chk("redirect_target", {39'd0, valid, pc, pc_next}, {39'd0, 1'b1, 8'd1, 8'd2});

        // Redirect while decode is stalled.
        ready = 1'b0;
        step();
        chk("stall_hold_valid", {47'd0, valid}, 48'd1);
        redir = 1'b1; rpc = 8'h40;
        step();
        redir = 1'b0; ready = 1'b1;
        chk("stall_redirect_valid", {47'd0, valid}, 48'd0);
        chk("stall_redirect_pc", {40'd0, addr}, 48'h40);

        // Disable: last word drains, PC held.
        step();
        step();
        en = 1'b0;
        step();
        step();
        chk("drain_valid", {47'd0, valid}, 48'd0);
        held_addr = addr;
        step();
        step();
        chk("idle_pc_held", {40'd0, addr}, {40'd0, held_addr});
        chk("idle_state", {47'd0, state}, 48'd0);

        // Async reset between edges.
        en = 1'b1;
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {47'd0, valid}, 48'd0);
        chk("async_rst_addr", {40'd0, addr}, 48'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            step();
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 9) == 0);
            rpc   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        // Drain everything that is still expected.
        step();
        en = 1'b0; ready = 1'b1; redir = 1'b0;
        repeat (5) step();
        chk("queue_empty", 48'(exp_q.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
